jtag_capture_update_chain: RTL
==============================

// Module: jtag_capture_update_chain
// PURPOSE
//   Parametrised JTAG data-register chain for the debug transport module: captures
//   a mixed constant/live word, shifts it LSB-first between TDI and TDO, and on
//   Update-DR delivers the shifted word over a valid/ready handshake. Successor to
//   the fixed 32-bit DTMCS chain; adds generic width, length checking, a held
//   update handshake with overrun detection, and sticky status flags.
// PARAMETERS
//   WIDTH          32          chain length in bits (>=2)
//   CAPTURE_MASK   {WIDTH{1'b0}} per bit: 1 = capture io_capture_bits[i], 0 = CAPTURE_CONST[i]
//   CAPTURE_CONST  {WIDTH{1'b0}} constant capture value for masked-off bits
//   CHECK_LENGTH   1           1 = suppress update when fewer than WIDTH bits shifted
// PORTS
//   clock               in   1      sole clock (TCK domain)
//   reset               in   1      asynchronous, active-low reset
//   io_chainIn_shift    in   1      Shift-DR
//   io_chainIn_data     in   1      TDI bit
//   io_chainIn_capture  in   1      Capture-DR
//   io_chainIn_update   in   1      Update-DR
//   io_chainOut_data    out  1      TDO bit = sr[0]
//   io_capture_bits     in   WIDTH  live capture value
//   io_capture_strobe   out  1      pulses in cycle a legal capture is accepted
//   io_update_valid     out  1      update word pending
//   io_update_ready     in   1      consumer accepts pending word
//   io_update_bits      out  WIDTH  update word, stable while valid
//   io_status_protocol  out  1      sticky: >1 of capture/shift/update in one cycle
//   io_status_short     out  1      sticky: update after < WIDTH shifts (CHECK_LENGTH=1)
//   io_status_overrun   out  1      sticky: update while previous word still pending
//   io_status_clear     in   1      clears all sticky flags
// BEHAVIOUR
//   State: sr[WIDTH-1:0], cnt[$clog2(WIDTH+1)-1:0] saturating at WIDTH, armed,
//   update_valid/update_bits, three sticky flags. Reset: all zero; TDO=0.
//   Legal cycle = at most one of capture/shift/update high. Illegal: sr, cnt,
//   armed unchanged; no strobe, no update; protocol flag set.
//   Capture: sr <= (io_capture_bits & MASK) | (CONST & ~MASK); cnt<=0; armed<=1;
//     io_capture_strobe = 1 same cycle (combinational on legal capture).
//   Shift: sr <= {io_chainIn_data, sr[WIDTH-1:1]}; cnt <= min(cnt+1, WIDTH).
//     Shifting past WIDTH is legal; last WIDTH bits in are retained.
//   Update (armed=1): armed<=0. If CHECK_LENGTH && cnt<WIDTH: short flag set,
//     no update. Else if update_valid && !io_update_ready: overrun flag set,
//     new word dropped, pending word kept. Else update_bits<=sr, update_valid<=1
//     next cycle (latency 1). Update with armed=0: ignored, no flags.
//   Handshake: update_valid held until valid&ready; clears next cycle. Accept and
//     new legal update in same cycle: new word loaded, valid stays 1, no overrun.
//   io_update_bits changes only on load; unchanged while valid && !ready.
//   Sticky flags: set wins over io_status_clear in same cycle.
//   Idle (no control): all state holds. sr not modified by update.
//   Async reset mid-scan: everything clears immediately; pending word lost.
// TESTING
//   W=8, MASK=8'h0F, CONST=8'hA0, capture_bits=8'h35 -> capture; TDO over 8 shifts
//     reads 1,0,1,0,0,1,0,1 (8'hA5 LSB-first); strobe 1 cycle.
//   Capture, shift in 8'h3C, update, ready=1 -> valid 1 cycle later, bits=8'h3C,
//     valid drops after accept.
//   Capture, 5 shifts, update -> no valid, status_short=1; clear -> 0.
//   Word pending with ready=0, second full scan+update -> overrun=1, bits keep
//     first word; same with ready=1 on update cycle -> second word, no overrun.
//   capture&shift high together -> sr unchanged, protocol=1, strobe=0.
//   Reset asserted mid-shift with valid=1 -> valid=0, TDO=0, flags=0 at once.

Source files
------------

// File: rtl/jtag_capture_update_chain_if.sv
// ---------------------------------------------------------------------------
// jtag_capture_update_chain_if
//   Update-word handshake between the JTAG data-register chain (producer)
//   and the debug-module side consumer.
//
//   io_update_valid  producer -> consumer  update word pending
//   io_update_ready  consumer -> producer  consumer accepts pending word
//   io_update_bits   producer -> consumer  update word, stable while valid
//
//   modport master : the chain (drives valid/bits, samples ready)
//   modport slave  : the consumer
// ---------------------------------------------------------------------------
interface jtag_capture_update_chain_if #(
  parameter int WIDTH = 32
);
  logic             io_update_valid;
  logic             io_update_ready;
  logic [WIDTH-1:0] io_update_bits;

  modport master (
    output io_update_valid,
    output io_update_bits,
    input  io_update_ready
  );

  modport slave (
    input  io_update_valid,
    input  io_update_bits,
    output io_update_ready
  );
endinterface : jtag_capture_update_chain_if

// File: rtl/jtag_capture_update_chain.sv
// ---------------------------------------------------------------------------
// jtag_capture_update_chain
//   Parametrised JTAG data-register chain. Capture-DR loads a word that mixes
//   constant and live bits, Shift-DR moves it LSB-first from TDI to TDO, and
//   Update-DR hands the shifted word to a consumer over a held valid/ready
//   handshake. Short scans, overruns and protocol violations raise sticky
//   status flags.
//
// Ports
//   clock               sole clock (TCK domain)
//   reset               asynchronous, active-low reset
//   io_chainIn_shift    Shift-DR
//   io_chainIn_data     TDI bit
//   io_chainIn_capture  Capture-DR
//   io_chainIn_update   Update-DR
//   io_chainOut_data    TDO bit (shift register bit 0)
//   io_capture_bits     live capture value
//   io_capture_strobe   high in the cycle a legal capture is accepted
//   upd                 update handshake (valid / ready / bits)
//   io_status_protocol  sticky: more than one of capture/shift/update high
//   io_status_short     sticky: update after fewer than WIDTH shifts
//   io_status_overrun   sticky: update while the previous word is pending
//   io_status_clear     clears all sticky flags (a same-cycle set wins)
// ---------------------------------------------------------------------------
module jtag_capture_update_chain #(
  parameter int               WIDTH         = 32,
  parameter logic [WIDTH-1:0] CAPTURE_MASK  = '0,
  parameter logic [WIDTH-1:0] CAPTURE_CONST = '0,
  parameter bit               CHECK_LENGTH  = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_chainIn_shift,
  input  logic                       io_chainIn_data,
  input  logic                       io_chainIn_capture,
  input  logic                       io_chainIn_update,
  output logic                       io_chainOut_data,
  input  logic [WIDTH-1:0]           io_capture_bits,
  output logic                       io_capture_strobe,
  jtag_capture_update_chain_if.master upd,
  output logic                       io_status_protocol,
  output logic                       io_status_short,
  output logic                       io_status_overrun,
  input  logic                       io_status_clear
);

  localparam int             CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  WIDTH_C = CW'(WIDTH);

  // Decoded TAP operation for this cycle.
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_CAPTURE,
    OP_SHIFT,
    OP_UPDATE,
    OP_ILLEGAL
  } op_e;

  op_e              op;

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] bits_q, bits_d;
  logic             protocol_q, protocol_d;
  logic             short_q, short_d;
  logic             overrun_q, overrun_d;

  logic             set_protocol, set_short, set_overrun;
  logic             accept;

  // Operation decode: any two controls high together is a protocol error.
  always_comb begin
    unique case ({io_chainIn_capture, io_chainIn_shift, io_chainIn_update})
      3'b000:  op = OP_IDLE;
      3'b100:  op = OP_CAPTURE;
      3'b010:  op = OP_SHIFT;
      3'b001:  op = OP_UPDATE;
      default: op = OP_ILLEGAL;
    endcase
  end

  assign accept = valid_q && upd.io_update_ready;

  always_comb begin
    // NOTE: every variable gets a hold/default value before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    armed_d      = armed_q;
    valid_d      = valid_q;
    bits_d       = bits_q;
    set_protocol = 1'b0;
    set_short    = 1'b0;
    set_overrun  = 1'b0;

    // A completed handshake drops valid unless a new word replaces it below.
    if (accept) valid_d = 1'b0;

    unique case (op)
      OP_CAPTURE: begin
        sr_d    = (io_capture_bits & CAPTURE_MASK) | (CAPTURE_CONST & ~CAPTURE_MASK);
        cnt_d   = '0;
        armed_d = 1'b1;
      end
      OP_SHIFT: begin
        sr_d  = {io_chainIn_data, sr_q[WIDTH-1:1]};
        cnt_d = (cnt_q == WIDTH_C) ? cnt_q : cnt_q + CW'(1);
      end
      OP_UPDATE: begin
        // An update without a preceding capture is silently ignored.
        if (armed_q) begin
          armed_d = 1'b0;
          if (CHECK_LENGTH && (cnt_q < WIDTH_C)) begin
            set_short = 1'b1;
          end else if (valid_q && !upd.io_update_ready) begin
            // Pending word wins; the new one is dropped.
            set_overrun = 1'b1;
          end else begin
            bits_d  = sr_q;
            valid_d = 1'b1;
          end
        end
      end
      OP_ILLEGAL: set_protocol = 1'b1;
      default: ;
    endcase
  end

  // Sticky flags: a set in the same cycle as clear takes priority.
  assign protocol_d = set_protocol | (protocol_q & ~io_status_clear);
  assign short_d    = set_short    | (short_q    & ~io_status_clear);
  assign overrun_d  = set_overrun  | (overrun_q  & ~io_status_clear);

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      valid_q    <= 1'b0;
      bits_q     <= '0;
      protocol_q <= 1'b0;
      short_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      valid_q    <= valid_d;
      bits_q     <= bits_d;
      protocol_q <= protocol_d;
      short_q    <= short_d;
      overrun_q  <= overrun_d;
    end
  end

  assign io_chainOut_data   = sr_q[0];
  assign io_capture_strobe  = (op == OP_CAPTURE);
  assign upd.io_update_valid = valid_q;
  assign upd.io_update_bits  = bits_q;
  assign io_status_protocol = protocol_q;
  assign io_status_short    = short_q;
  assign io_status_overrun  = overrun_q;

endmodule : jtag_capture_update_chain
